// File: rtl/cl_tnn_pkg.sv
// Shared types and AXI4 constants for the TNN result writer.
package cl_tnn_pkg;

  localparam int         BYTES_PER_WORD = 64;
  localparam logic [2:0] AXSIZE_64B     = 3'b110;
  localparam logic [1:0] BURST_INCR     = 2'b01;
  localparam logic [1:0] RESP_OKAY      = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } state_t;

  // awlen for the next burst: min(max_burst, remaining) - 1
  function automatic logic [7:0] burst_len(input logic [15:0] remaining, input int max_burst);
    logic [15:0] cap;
    cap = 16'(max_burst);
    if (remaining < cap) burst_len = 8'(remaining - 16'd1);
    else                 burst_len = 8'(cap - 16'd1);
  endfunction

endpackage

// File: rtl/cl_tnn_result_wr.sv
// Writes one image of 512-bit TNN results to memory as a chain of AXI4
// INCR bursts, with a single burst outstanding at any time.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; cfg latched on start
// ST_AW   | awvalid held with stable addr/len until awready
// ST_W    | stream passes straight through to the W channel
// ST_B    | bready high, waiting for the write response
// ST_DONE | done pulse for one cycle, then back to idle
module cl_tnn_result_wr
  import cl_tnn_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [511:0] in_bits,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [63:0]  cfg_base_addr,
  input  logic [15:0]  cfg_words,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [63:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [511:0] wdata,
  output logic [63:0]  wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  state_t      state_q;
  logic [63:0] addr_q;
  logic [15:0] remaining_q;
  logic [7:0]  len_q;
  logic [7:0]  beat_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        awvalid_q;
  logic        bready_q;

  logic        in_w;
  logic [15:0] burst_beats;
  logic [15:0] rem_next;

  assign in_w = (state_q == ST_W);

  // W channel is a pure pass-through of the stream, gated to the W state
  assign wdata   = in_bits;
  assign wstrb   = '1;
  assign wvalid  = in_w & in_vld;
  assign in_rdy  = in_w & wready;
  assign wlast   = in_w & (beat_q == len_q);

  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = AXSIZE_64B;
  assign awburst = BURST_INCR;
  assign awvalid = awvalid_q;
  assign bready  = bready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

  // Beats in the burst that the pending response closes
  always_comb begin
    burst_beats = {8'd0, len_q} + 16'd1;
    rem_next    = remaining_q - burst_beats;
  end

  // Burst sequencing FSM with registered control outputs
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      awvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
            addr_q      <= cfg_base_addr;
            remaining_q <= cfg_words;
            if (cfg_words == 16'd0) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              len_q     <= burst_len(cfg_words, MAX_BURST);
              awvalid_q <= 1'b1;
              state_q   <= ST_AW;
            end
          end
        end
        ST_AW: begin
          if (awready) begin
            awvalid_q <= 1'b0;
            beat_q    <= '0;
            state_q   <= ST_W;
          end
        end
        ST_W: begin
          if (in_vld && wready) begin
            if (beat_q == len_q) begin
              bready_q <= 1'b1;
              state_q  <= ST_B;
            end else begin
              beat_q <= beat_q + 8'd1;
            end
          end
        end
        ST_B: begin
          if (bvalid) begin
            bready_q    <= 1'b0;
            if (bresp != RESP_OKAY) err_q <= 1'b1;
            addr_q      <= addr_q + 64'(burst_beats) * 64'(BYTES_PER_WORD);
            remaining_q <= rem_next;
            if (rem_next != 16'd0) begin
              len_q     <= burst_len(rem_next, MAX_BURST);
              awvalid_q <= 1'b1;
              state_q   <= ST_AW;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cl_tnn_result_wr.sv
// Directed bench for cl_tnn_result_wr with a scoreboard of expected AW and
// W beats, a stream source model and a simple AXI slave model.
module tb_cl_tnn_result_wr;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [511:0] in_bits = '0;
  logic         in_vld = 1'b0;
  logic         in_rdy;
  logic [63:0]  cfg_base_addr = '0;
  logic [15:0]  cfg_words = '0;
  logic         start = 1'b0;
  logic         busy, done, err;
  logic [63:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready = 1'b0;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast, wvalid;
  logic         wready = 1'b0;
  logic [1:0]   bresp = 2'b00;
  logic         bvalid = 1'b0;
  logic         bready;

  cl_tnn_result_wr #(.MAX_BURST(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_bits(in_bits), .in_vld(in_vld), .in_rdy(in_rdy),
    .cfg_base_addr(cfg_base_addr), .cfg_words(cfg_words),
    .start(start), .busy(busy), .done(done), .err(err),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [63:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [511:0] data; logic last; } w_t;

  aw_t          exp_aw[$];
  w_t           exp_w[$];
  logic [511:0] src[$];
  logic [1:0]   bresp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int w_beats = 0;
  int ctl_seen = 0;
  int last_b_cyc = -100;
  int outstanding = 0;
  int vld_gap = 0, rdy_gap = 0, aw_gap = 0;
  bit in_fire = 0, wl_fire = 0, b_fire = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: handshakes sampled on the falling edge
  initial begin : mon
    aw_t a;
    w_t  wx;
    forever begin
      @(negedge aclk);
      cyc++;
      in_fire = 0;
      wl_fire = 0;
      b_fire  = 0;
      if (!aresetn) begin
        outstanding = 0;
      end else begin
        if (awvalid || wvalid || in_rdy) ctl_seen++;
        if (awvalid && awready) begin
          chk("one_outstanding", outstanding, 0);
          outstanding = 1;
          chk("aw_expected", exp_aw.size() != 0, 1'b1);
          if (exp_aw.size() != 0) begin
            a = exp_aw.pop_front();
            chk("awaddr", awaddr, a.addr);
            chk("awlen", awlen, a.len);
            chk("awsize", awsize, 3'b110);
            chk("awburst", awburst, 2'b01);
          end
        end
        if ((in_vld && in_rdy) || (wvalid && wready))
          chk("stream_link", in_vld && in_rdy, wvalid && wready);
        if (wvalid && wready) begin
          w_beats++;
          chk("w_expected", exp_w.size() != 0, 1'b1);
          if (exp_w.size() != 0) begin
            wx = exp_w.pop_front();
            chk("wdata", wdata, wx.data);
            chk("wlast", wlast, wx.last);
            chk("wstrb", wstrb, {64{1'b1}});
          end
          wl_fire = wlast;
        end
        in_fire = in_vld && in_rdy;
        if (bvalid && bready) begin
          b_fire = 1;
          last_b_cyc = cyc;
          outstanding = 0;
        end
      end
    end
  end

  // Stream source and AXI slave models, driven just after the rising edge
  initial begin : drv
    forever begin
      @(posedge aclk);
      #1;
      if (in_fire && src.size() > 0) src.delete(0);
      if (b_fire || !aresetn) bvalid = 1'b0;
      if (wl_fire && aresetn) begin
        bvalid = 1'b1;
        bresp  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
      end
      in_vld  = (src.size() > 0) && (int'($urandom_range(99)) >= vld_gap);
      in_bits = (src.size() > 0) ? src[0] : '0;
      wready  = int'($urandom_range(99)) >= rdy_gap;
      awready = int'($urandom_range(99)) >= aw_gap;
    end
  end

  task automatic load_image(input logic [63:0] base, input int words, input bit bad_first);
    logic [63:0]  a;
    logic [511:0] d;
    int           rem;
    int           len;
    bit           first;
    a = base;
    rem = words;
    first = 1;
    while (rem > 0) begin
      len = (rem < 16) ? rem : 16;
      exp_aw.push_back('{a, 8'(len - 1)});
      bresp_q.push_back((bad_first && first) ? 2'b10 : 2'b00);
      first = 0;
      for (int i = 0; i < len; i++) begin
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
        src.push_back(d);
        exp_w.push_back('{d, (i == len - 1)});
      end
      a = a + 64'(len * 64);
      rem = rem - len;
    end
    cfg_base_addr = base;
    cfg_words = 16'(words);
  endtask

  task automatic run_image(input logic [63:0] base, input int words, input bit bad_first,
                           input bit exp_err);
    bit got;
    load_image(base, words, bad_first);
    @(posedge aclk); #1;
    start = 1'b1;
    if (words != 0) begin
      // second start cycle with different cfg must be ignored
      @(posedge aclk); #1;
      cfg_base_addr = base + 64'h40000;
      cfg_words = 16'(words + 3);
    end
    @(posedge aclk); #1;
    start = 1'b0;
    cfg_base_addr = base;
    cfg_words = 16'(words);
    got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge aclk);
      if (i == 0) begin
        chk("busy_after_start", busy, 1'b1);
        chk("err_cleared", err, 1'b0);
      end
      if (done) got = 1;
    end
    chk("done_seen", got, 1'b1);
    chk("busy_at_done", busy, 1'b1);
    chk("err_at_done", err, exp_err);
    chk("aw_drained", exp_aw.size(), 0);
    chk("w_drained", exp_w.size(), 0);
    if (words != 0) chk("done_after_b", cyc - last_b_cyc, 1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_awvalid"}, awvalid, 1'b0);
    chk({tag, "_wvalid"}, wvalid, 1'b0);
    chk({tag, "_wlast"}, wlast, 1'b0);
    chk({tag, "_bready"}, bready, 1'b0);
    chk({tag, "_in_rdy"}, in_rdy, 1'b0);
  endtask

  initial begin : seq
    int base_beats;
    bit hit;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk_idle_outputs("reset");
    @(posedge aclk); #1;
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);

    // single full burst, one cycle of done
    run_image(64'h1000, 16, 0, 0);
    @(negedge aclk);
    chk("done_pulse_width", done, 1'b0);
    chk("busy_after_done", busy, 1'b0);

    // three bursts with a short tail
    run_image(64'h0, 37, 0, 0);

    // random stream and slave gaps
    vld_gap = 30; rdy_gap = 30; aw_gap = 30;
    run_image(64'h0000_0001_0000_0C00, 20, 0, 0);
    vld_gap = 0; rdy_gap = 0; aw_gap = 0;

    // error response on the first burst is sticky, next start clears it
    run_image(64'h8000, 32, 1, 1);
    run_image(64'h9000, 8, 0, 0);

    // reset while beat 5 of a 16-beat burst is pending
    base_beats = w_beats;
    load_image(64'h4000, 16, 0);
    @(posedge aclk); #1;
    start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge aclk);
      if (w_beats - base_beats >= 4) hit = 1;
    end
    chk("reached_beat5", w_beats - base_beats, 4);
    @(posedge aclk); #1;
    aresetn = 1'b0;
    exp_aw.delete();
    exp_w.delete();
    src.delete();
    bresp_q.delete();
    @(posedge aclk);
    @(negedge aclk);
    chk_idle_outputs("midreset");
    @(posedge aclk); #1;
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    run_image(64'h4000, 16, 0, 0);

    // zero words back-to-back, then another image in the following idle cycle
    ctl_seen = 0;
    run_image(64'h2000, 0, 0, 0);
    chk("zero_no_traffic", ctl_seen, 0);
    run_image(64'h400, 3, 0, 0);

    repeat (3) @(posedge aclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
